// File: rtl/rvx_machine_timer_pkg.sv
// Shared register map, control field positions and helpers for the machine timer.
// Byte addresses are 5 bits wide because the block decodes a 32-byte window.
package rvx_machine_timer_pkg;

    localparam logic [4:0] RVX_TIMER_MTIME_ADDR      = 5'h00;
    localparam logic [4:0] RVX_TIMER_MTIMEH_ADDR     = 5'h04;
    localparam logic [4:0] RVX_TIMER_MTIMECMP_ADDR   = 5'h08;
    localparam logic [4:0] RVX_TIMER_MTIMECMPH_ADDR  = 5'h0C;
    localparam logic [4:0] RVX_TIMER_CONTROL_ADDR    = 5'h10;

    localparam int RVX_TIMER_CONTROL_ENABLE_BIT  = 0;
    localparam int RVX_TIMER_CONTROL_DIVISOR_LSB = 8;

    localparam logic [63:0] RVX_TIMER_MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        SEL_MTIME,
        SEL_MTIMEH,
        SEL_MTIMECMP,
        SEL_MTIMECMPH,
        SEL_CONTROL,
        SEL_RESERVED
    } timer_sel_e;

    function automatic timer_sel_e decode_address(input logic [2:0] word_address);
        timer_sel_e sel;
        sel = SEL_RESERVED;
        if (word_address == RVX_TIMER_MTIME_ADDR[4:2])     sel = SEL_MTIME;
        if (word_address == RVX_TIMER_MTIMEH_ADDR[4:2])    sel = SEL_MTIMEH;
        if (word_address == RVX_TIMER_MTIMECMP_ADDR[4:2])  sel = SEL_MTIMECMP;
        if (word_address == RVX_TIMER_MTIMECMPH_ADDR[4:2]) sel = SEL_MTIMECMPH;
        if (word_address == RVX_TIMER_CONTROL_ADDR[4:2])   sel = SEL_CONTROL;
        return sel;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_value,
                                                input logic [31:0] new_value,
                                                input logic [3:0]  strobe);
        logic [31:0] merged;
        merged = old_value;
        for (int i = 0; i < 4; i++) begin
            if (strobe[i]) merged[8*i +: 8] = new_value[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/rvx_timer_prescaler.sv
// Programmable divider: counts 0..divisor while enabled and emits a one-cycle tick
// in the cycle where the count equals the divisor.
module rvx_timer_prescaler
    import rvx_machine_timer_pkg::*;
#(
    parameter int PRESCALER_WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [PRESCALER_WIDTH-1:0] divisor,
    input  logic                       clear,
    output logic                       tick
);

    logic [PRESCALER_WIDTH-1:0] count;

    assign tick = enable && (count == divisor);

    // The tick is judged on the pre-edge count, so a clear only affects later cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else if (enable) begin
            count <= count + PRESCALER_WIDTH'(1);
        end
    end

endmodule

// File: rtl/rvx_machine_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp with prescaler, 32-bit bus access
// and a registered level interrupt for the CSR file.
module rvx_machine_timer
    import rvx_machine_timer_pkg::*;
#(
    parameter int PRESCALER_WIDTH = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  rw_address,
    input  logic        read_request,
    output logic [31:0] read_data,
    output logic        read_response,
    input  logic        write_request,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_strobe,
    output logic        write_response,
    output logic [63:0] memory_mapped_timer,
    output logic        irq_timer
);

    logic [63:0]                mtime;
    logic [63:0]                mtimecmp;
    logic                       enable;
    logic [PRESCALER_WIDTH-1:0] divisor;
    logic                       tick;
    timer_sel_e                 sel;
    logic                       control_write;
    logic [31:0]                control_image;
    logic [31:0]                control_merged;
    logic [31:0]                read_value;
    logic                       unused_bits;

    assign sel           = decode_address(rw_address[4:2]);
    assign control_write = write_request && (sel == SEL_CONTROL);
    assign unused_bits   = ^{rw_address[1:0], control_merged};

    always_comb begin
        control_image = '0;
        control_image[RVX_TIMER_CONTROL_ENABLE_BIT] = enable;
        control_image[RVX_TIMER_CONTROL_DIVISOR_LSB +: PRESCALER_WIDTH] = divisor;
    end

    assign control_merged = merge_bytes(control_image, write_data, write_strobe);

    always_comb begin
        read_value = '0;
        case (sel)
            SEL_MTIME:     read_value = mtime[31:0];
            SEL_MTIMEH:    read_value = mtime[63:32];
            SEL_MTIMECMP:  read_value = mtimecmp[31:0];
            SEL_MTIMECMPH: read_value = mtimecmp[63:32];
            SEL_CONTROL:   read_value = control_image;
            default:       read_value = '0;
        endcase
    end

    rvx_timer_prescaler #(
        .PRESCALER_WIDTH(PRESCALER_WIDTH)
    ) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .divisor (divisor),
        .clear   (control_write),
        .tick    (tick)
    );

    // A software write to either half wins over a coincident tick for the whole counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mtime <= '0;
        end else if (write_request && sel == SEL_MTIME) begin
            mtime[31:0] <= merge_bytes(mtime[31:0], write_data, write_strobe);
        end else if (write_request && sel == SEL_MTIMEH) begin
            mtime[63:32] <= merge_bytes(mtime[63:32], write_data, write_strobe);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mtimecmp <= RVX_TIMER_MTIMECMP_RESET;
            enable   <= 1'b1;
            divisor  <= '0;
        end else if (write_request) begin
            if (sel == SEL_MTIMECMP)
                mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], write_data, write_strobe);
            if (sel == SEL_MTIMECMPH)
                mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], write_data, write_strobe);
            if (sel == SEL_CONTROL) begin
                enable  <= control_merged[RVX_TIMER_CONTROL_ENABLE_BIT];
                divisor <= control_merged[RVX_TIMER_CONTROL_DIVISOR_LSB +: PRESCALER_WIDTH];
            end
        end
    end

    // Read data captures the pre-update register value; it holds between reads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_data      <= '0;
            read_response  <= 1'b0;
            write_response <= 1'b0;
            irq_timer      <= 1'b0;
        end else begin
            read_response  <= read_request;
            write_response <= write_request;
            irq_timer      <= (mtime >= mtimecmp);
            if (read_request) read_data <= read_value;
        end
    end

    assign memory_mapped_timer = mtime;

endmodule
